// File: rtl/nn_neuron_mac.sv
// nn_neuron_mac
// Single-neuron multiply-accumulate stage. Drains N_INPUTS activation words
// from a show-ahead FIFO, multiplies each by a locally stored signed weight,
// accumulates onto a bias, then saturates to 32 bits and optionally applies
// ReLU. The result is offered on a valid/ready port.
//
// Parameters
//   N_INPUTS  activations per evaluation (1..8)
//   ACC_W     accumulator width, >= 32 + clog2(N_INPUTS) + 1
//
// Ports
//   clk, rst         clock (rising edge), synchronous active-high reset
//   start            one-cycle pulse starting an evaluation (IDLE only)
//   relu_en, bias    sampled together with start
//   w_we/addr/data   weight RAM write port (IDLE only)
//   in_valid/in_data FIFO not-empty flag and head word ([15:0] = activation)
//   in_pop           pop request; FIFO head advances after the edge
//   out_valid/ready  result handshake
//   out_data         signed 32-bit neuron result
//   busy             high in any state other than IDLE

module nn_neuron_mac #(
    parameter int N_INPUTS = 8,
    parameter int ACC_W    = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               relu_en,
    input  logic signed [31:0] bias,
    input  logic               w_we,
    input  logic [2:0]         w_addr,
    input  logic signed [15:0] w_data,
    input  logic               in_valid,
    input  logic [31:0]        in_data,
    output logic               in_pop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic               busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FINAL,
        S_RESULT
    } state_t;

    state_t state, state_nxt;

    logic signed [15:0]      weight [8];
    logic signed [ACC_W-1:0] acc;
    logic [2:0]              idx;
    logic                    relu_q;

    logic                    last_pop;
    logic signed [31:0]      w_ext;
    logic signed [31:0]      a_ext;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] bias_ext;
    logic                    acc_fits;
    logic signed [31:0]      sat_val;
    logic signed [31:0]      result;

    // Upper half of the FIFO word carries no activation data.
    logic unused_in_hi;
    assign unused_in_hi = ^in_data[31:16];

    // ------------------------------------------------------------------
    // Datapath arithmetic
    // ------------------------------------------------------------------
    // Both operands are widened to 32 bits first so the 16x16 product is
    // exact in a 32-bit signed result without relying on context sizing.
    assign w_ext    = {{16{weight[idx][15]}}, weight[idx]};
    assign a_ext    = {{16{in_data[15]}}, in_data[15:0]};
    assign prod     = w_ext * a_ext;
    assign prod_ext = {{(ACC_W-32){prod[31]}}, prod};
    assign bias_ext = {{(ACC_W-32){bias[31]}}, bias};

    // The accumulator fits in 32 bits when every bit from 31 upward is a
    // copy of the sign; otherwise clamp toward the sign.
    assign acc_fits = (&acc[ACC_W-1:31]) | ~(|acc[ACC_W-1:31]);
    assign sat_val  = acc_fits ? acc[31:0]
                    : (acc[ACC_W-1] ? 32'sh8000_0000 : 32'sh7FFF_FFFF);
    assign result   = (relu_q && sat_val[31]) ? 32'sd0 : sat_val;

    // idx reaches N_INPUTS-1 on the final pop; it may wrap afterwards, which
    // is harmless because the state leaves ACCUM on that same edge.
    assign last_pop = in_pop && (idx == 3'(N_INPUTS - 1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_pop    = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_ACCUM;
            end
            S_ACCUM: begin
                // Never pop an empty FIFO.
                in_pop = in_valid;
                if (last_pop) state_nxt = S_FINAL;
            end
            S_FINAL: begin
                state_nxt = S_RESULT;
            end
            S_RESULT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Weights, accumulator, result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) weight[i] <= '0;
            acc      <= '0;
            idx      <= '0;
            relu_q   <= 1'b0;
            out_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (w_we) weight[w_addr] <= w_data;
                    if (start) begin
                        acc    <= bias_ext;
                        idx    <= '0;
                        relu_q <= relu_en;
                    end
                end
                S_ACCUM: begin
                    if (in_pop) begin
                        acc <= acc + prod_ext;
                        idx <= idx + 3'd1;
                    end
                end
                S_FINAL: begin
                    out_data <= result;
                end
                default: ;
            endcase
        end
    end

endmodule
